bp_sacc_csr_responder: RTL and testbench
========================================

# bp_sacc_csr_responder

Responder end of the accelerator tile's I/O command path. It accepts uncached BedRock memory commands delivered by the tile's I/O CCE (`io_cmd`) and returns one BedRock response per command (`io_resp`). It hosts the accelerator's control/status register page and drives the start/configuration signals into the accelerator datapath. It sits between `bp_io_cce` and the accelerator compute core inside a `sacc` tile.

## Interface
- `bp_params_p`, default `e_bp_default_cfg`: proc config; supplies `paddr_width_p` and `cce_block_width_p`.
- `cycle_cnt_width_p`, default 32: width of the busy-cycle counter.
- `mem_msg_width_lp`, localparam: `$bits(bp_bedrock_cce_mem_msg_s)`.

Ports:
- `clk_i` in 1: clock.
- `reset_i` in 1: synchronous, active-high reset.
- `io_cmd_i` in `mem_msg_width_lp`: command message; uses `header.msg_type`, `addr`, `size`, `payload`, and `data[63:0]`.
- `io_cmd_v_i` in 1: command valid.
- `io_cmd_ready_o` out 1: ready; accept = `v_i & ready_o`.
- `io_resp_o` out `mem_msg_width_lp`: response message.
- `io_resp_v_o` out 1: response valid.
- `io_resp_yumi_i` in 1: consumer takes the response; legal only while `v_o`=1.
- `start_o` out 1: one-cycle start pulse to the datapath.
- `a_addr_o` out `paddr_width_p`: operand A base address.
- `b_addr_o` out `paddr_width_p`: operand B base address.
- `len_o` out 32: element count.
- `busy_o` out 1: datapath running.
- `done_i` in 1: one-cycle completion pulse from the datapath.
- `result_i` in 64: datapath result; valid in the `done_i` cycle.

## Operation
- FSM has two states.
  - `e_ready`: `io_cmd_ready_o`=1. On accept, perform the register access and go to `e_resp`.
  - `e_resp`: `io_cmd_ready_o`=0 and `io_resp_v_o`=1. On `io_resp_yumi_i`, go to `e_ready`.
- One command is outstanding at a time, so there is no reordering.
- Response header: copy of the accepted command header (`msg_type`, `addr`, `size`, `payload`), registered at accept.
  - Response data for `e_bedrock_mem_uc_rd`: the read value, zero-extended to the block width.
  - Response data for all other cases: 0.
- Decode uses `addr[5:3]` as the register index. Nonzero `addr[2:0]` or `addr[11:6]` means unmapped. Upper address bits are ignored.
- Register map (offset: name, access):
  - 0x00: A_ADDR, RW, low `paddr_width_p` bits.
  - 0x08: B_ADDR, RW.
  - 0x10: LEN, RW, low 32 bits.
  - 0x18: START, WO.
    - Write with `data[0]`=1 while not busy: pulse `start_o` the next cycle, set busy, clear done, clear CYCLES.
    - Write while busy: ignored.
    - Reads return 0.
  - 0x20: STATUS, read value `{62'b0, done, busy}`. Writing 1 to bit 1 clears done (W1C). Bit 0 is read-only.
  - 0x28: RESULT, RO; captures `result_i` when `done_i`=1.
  - 0x30: CYCLES, RO; counts cycles with busy=1 and saturates at all-ones.
- Writes ignore `size` and always use `data[63:0]` truncated to the register width.
- Unmapped reads return 0. Unmapped writes and writes to RO registers are dropped. A response is still produced in every case.
- Message types other than `uc_rd`/`uc_wr` are treated as a no-op write; a response is still produced.
- On `done_i`: clear busy, set done, latch RESULT.
  - `done_i` while not busy is ignored.
  - `done_i` in the same cycle as an accepted START write: done is processed first, then the START write sees busy=0 and starts a new run.
  - A STATUS W1C in the same cycle as `done_i`: the set wins, so done=1.

## Timing
- Reset values: state `e_ready`; `io_cmd_ready_o`=1 in the first cycle after reset; `io_resp_v_o`=0; `start_o`=0; `busy_o`=0; done=0; all registers 0.
- Latency: command accepted in cycle N gives `io_resp_v_o`=1 in cycle N+1. The next command can be accepted in the cycle after yumi, for a maximum throughput of one command per 2 cycles.
- Register writes take effect at the accept edge. `start_o` is asserted in cycle N+1, and `busy_o` rises in cycle N+1.
- A read in cycle N returns register contents as of the start of cycle N, including a `done_i` arriving in cycle N-1.
- `io_resp_o` and `io_resp_v_o` are held stable until yumi.
- Reset mid-transaction drops any pending response and clears busy without pulsing `start_o`.

## Test plan
- Write A_ADDR=0x8000_1000, B_ADDR=0x8000_2000, LEN=16, then read each back -> response data matches, each response arrives 1 cycle after accept, and the response header equals the command header.
- Write START=1 -> `start_o` pulses for exactly 1 cycle and STATUS reads 0x1. Hold for 10 cycles, then pulse `done_i` with `result_i`=0xDEAD_BEEF -> STATUS=0x2, RESULT=0xDEAD_BEEF, CYCLES=10 (±1 per the defined edge).
- Write START while busy -> no `start_o` and busy stays 1. Write STATUS=0x2 after done -> STATUS=0x0.
- `done_i` coincident with an accepted START write -> done observed and a new run starts, so STATUS=0x1 and `start_o` pulses once.
- Read offset 0x38, read 0x04, write RESULT, and send an unknown `msg_type` -> responses return data 0 and no register changes.
- Hold `io_resp_yumi_i`=0 for 5 cycles while `io_cmd_v_i`=1 -> `io_cmd_ready_o`=0 and the response is stable. Assert `reset_i` mid-wait -> `io_resp_v_o`=0 and all registers 0 in the next cycle.

Source files
------------

// File: rtl/bp_sacc_csr_responder.sv
// CSR responder for the sacc accelerator tile. It serves one uncached BedRock command at a time
// and drives the datapath start/config. Message layout: {data, payload, size, addr, msg_type}, with msg_type in the LSBs.
module bp_sacc_csr_responder #(
    parameter int  paddr_width_p     = 40,
    parameter int  cce_block_width_p = 128,
    parameter int  payload_width_p   = 16,
    parameter int  cycle_cnt_width_p = 32,
    localparam int mem_hdr_width_lp  = payload_width_p + 3 + paddr_width_p + 4,
    localparam int mem_msg_width_lp  = cce_block_width_p + mem_hdr_width_lp
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [mem_msg_width_lp-1:0] io_cmd_i,
    input  logic                        io_cmd_v_i,
    output logic                        io_cmd_ready_o,
    output logic [mem_msg_width_lp-1:0] io_resp_o,
    output logic                        io_resp_v_o,
    input  logic                        io_resp_yumi_i,
    output logic                        start_o,
    output logic [paddr_width_p-1:0]    a_addr_o,
    output logic [paddr_width_p-1:0]    b_addr_o,
    output logic [31:0]                 len_o,
    output logic                        busy_o,
    input  logic                        done_i,
    input  logic [63:0]                 result_i
);

    localparam logic [3:0] e_bedrock_mem_uc_rd = 4'd2;
    localparam logic [3:0] e_bedrock_mem_uc_wr = 4'd3;

    typedef struct packed {
        logic [payload_width_p-1:0] payload;
        logic [2:0]                 size;
        logic [paddr_width_p-1:0]   addr;
        logic [3:0]                 msg_type;
    } mem_hdr_s;

    typedef struct packed {
        logic [cce_block_width_p-1:0] data;
        mem_hdr_s                     header;
    } mem_msg_s;

    typedef enum logic {
        e_ready = 1'b0,
        e_resp  = 1'b1
    } state_e;

    state_e   state;
    logic     ready;
    logic     resp_v;
    mem_msg_s resp;
    mem_msg_s cmd;

    logic [paddr_width_p-1:0]     a_addr;
    logic [paddr_width_p-1:0]     b_addr;
    logic [31:0]                  len;
    logic                         busy;
    logic                         done;
    logic                         start;
    logic [63:0]                  result;
    logic [cycle_cnt_width_p-1:0] cycles;

    logic                         accept;
    logic                         mapped;
    logic [2:0]                   idx;
    logic                         is_rd;
    logic                         is_wr;
    logic                         wr_fire;
    logic                         done_fire;
    logic                         start_fire;
    logic [63:0]                  wdata;
    logic [63:0]                  rd_val;
    logic [cce_block_width_p-1:0] resp_data;
    logic                         unused_data;

    assign cmd         = mem_msg_s'(io_cmd_i);
    assign wdata       = cmd.data[63:0];
    assign unused_data = ^cmd.data[cce_block_width_p-1:64];

    assign accept  = io_cmd_v_i & ready;
    assign idx     = cmd.header.addr[5:3];
    assign mapped  = (cmd.header.addr[2:0] == 3'b0) && (cmd.header.addr[11:6] == 6'b0);
    assign is_rd   = (cmd.header.msg_type == e_bedrock_mem_uc_rd);
    assign is_wr   = (cmd.header.msg_type == e_bedrock_mem_uc_wr);
    assign wr_fire = accept & is_wr & mapped;

    // Completion is applied before a coincident START write, so that write sees the datapath idle.
    assign done_fire  = done_i & busy;
    assign start_fire = wr_fire & (idx == 3'd3) & wdata[0] & (~busy | done_i);

    always_comb begin
        rd_val = '0;
        if (mapped) begin
            case (idx)
                3'd0:    rd_val[paddr_width_p-1:0]     = a_addr;
                3'd1:    rd_val[paddr_width_p-1:0]     = b_addr;
                3'd2:    rd_val[31:0]                  = len;
                3'd4:    rd_val[1:0]                   = {done, busy};
                3'd5:    rd_val                        = result;
                3'd6:    rd_val[cycle_cnt_width_p-1:0] = cycles;
                default: rd_val = '0;
            endcase
        end
    end

    always_comb begin
        resp_data = '0;
        if (is_rd) begin
            resp_data[63:0] = rd_val;
        end
    end

    // Command/response handshake: a command is taken when io_cmd_v_i & io_cmd_ready_o; the response
    // is held unchanged while io_resp_v_o is high and retired by io_resp_yumi_i.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state  <= e_ready;
            ready  <= 1'b1;
            resp_v <= 1'b0;
            resp   <= '0;
        end else begin
            case (state)
                e_ready: begin
                    if (accept) begin
                        state       <= e_resp;
                        ready       <= 1'b0;
                        resp_v      <= 1'b1;
                        resp.header <= cmd.header;
                        resp.data   <= resp_data;
                    end
                end
                e_resp: begin
                    if (io_resp_yumi_i) begin
                        state  <= e_ready;
                        ready  <= 1'b1;
                        resp_v <= 1'b0;
                    end
                end
                default: begin
                    state  <= e_ready;
                    ready  <= 1'b1;
                    resp_v <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            a_addr <= '0;
            b_addr <= '0;
            len    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            start  <= 1'b0;
            result <= '0;
            cycles <= '0;
        end else begin
            start <= start_fire;

            if (busy && (cycles != '1)) begin
                cycles <= cycles + 1'b1;
            end

            if (done_fire) begin
                busy   <= 1'b0;
                done   <= 1'b1;
                result <= result_i;
            end

            if (wr_fire) begin
                case (idx)
                    3'd0: a_addr <= wdata[paddr_width_p-1:0];
                    3'd1: b_addr <= wdata[paddr_width_p-1:0];
                    3'd2: len    <= wdata[31:0];
                    // W1C of done loses to a completion arriving in the same cycle.
                    3'd4: if (wdata[1] && !done_fire) done <= 1'b0;
                    default: ;
                endcase
            end

            if (start_fire) begin
                busy   <= 1'b1;
                done   <= 1'b0;
                cycles <= '0;
            end
        end
    end

    assign io_cmd_ready_o = ready;
    assign io_resp_v_o    = resp_v;
    assign io_resp_o      = resp;
    assign start_o        = start;
    assign a_addr_o       = a_addr;
    assign b_addr_o       = b_addr;
    assign len_o          = len;
    assign busy_o         = busy;

endmodule

// File: tb/tb_bp_sacc_csr_responder.sv
// Self-checking bench for bp_sacc_csr_responder: register model plus expected-response queue.
module tb_bp_sacc_csr_responder;

    localparam int paddr_w   = 40;
    localparam int block_w   = 128;
    localparam int payload_w = 16;
    localparam int hdr_w     = payload_w + 3 + paddr_w + 4;
    localparam int msg_w     = block_w + hdr_w;

    localparam logic [3:0] mt_uc_rd = 4'd2;
    localparam logic [3:0] mt_uc_wr = 4'd3;
    localparam logic [3:0] mt_amo   = 4'd5;

    // clock / reset
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [msg_w-1:0]   io_cmd_i       = '0;
    logic               io_cmd_v_i     = 1'b0;
    logic               io_cmd_ready_o;
    logic [msg_w-1:0]   io_resp_o;
    logic               io_resp_v_o;
    logic               io_resp_yumi_i = 1'b0;
    logic               start_o;
    logic [paddr_w-1:0] a_addr_o;
    logic [paddr_w-1:0] b_addr_o;
    logic [31:0]        len_o;
    logic               busy_o;
    logic               done_i         = 1'b0;
    logic [63:0]        result_i       = '0;

    bp_sacc_csr_responder dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .io_cmd_i       (io_cmd_i),
        .io_cmd_v_i     (io_cmd_v_i),
        .io_cmd_ready_o (io_cmd_ready_o),
        .io_resp_o      (io_resp_o),
        .io_resp_v_o    (io_resp_v_o),
        .io_resp_yumi_i (io_resp_yumi_i),
        .start_o        (start_o),
        .a_addr_o       (a_addr_o),
        .b_addr_o       (b_addr_o),
        .len_o          (len_o),
        .busy_o         (busy_o),
        .done_i         (done_i),
        .result_i       (result_i)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    logic [msg_w-1:0] exp_q[$];
    logic [msg_w-1:0] last_exp;

    int edge_n    = 0;
    int start_cnt = 0;
    always @(posedge clk) edge_n <= edge_n + 1;
    always @(negedge clk) if (start_o === 1'b1) start_cnt <= start_cnt + 1;

    // register model
    logic [paddr_w-1:0] m_a;
    logic [paddr_w-1:0] m_b;
    logic [31:0]        m_len;
    logic               m_busy;
    logic               m_done;
    logic [63:0]        m_result;
    int                 t_start;
    int                 t_done;

    task automatic check(input string tag, input logic [msg_w-1:0] got, input logic [msg_w-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_a      = '0;
        m_b      = '0;
        m_len    = '0;
        m_busy   = 1'b0;
        m_done   = 1'b0;
        m_result = '0;
        t_start  = 0;
        t_done   = 0;
    endtask

    // Value a read accepted at edge e observes (state after edge e-1).
    function automatic logic [63:0] model_read(input logic [paddr_w-1:0] addr, input int e);
        logic [63:0] v;
        v = '0;
        if (addr[2:0] == 3'b0 && addr[11:6] == 6'b0) begin
            case (addr[5:3])
                3'd0:    v = 64'(m_a);
                3'd1:    v = 64'(m_b);
                3'd2:    v = 64'(m_len);
                3'd4:    v = {62'b0, m_done, m_busy};
                3'd5:    v = m_result;
                3'd6:    v = 64'(m_busy ? (e - 1 - t_start) : (t_done - t_start));
                default: v = '0;
            endcase
        end
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // driver: one command, optional coincident done pulse, optional stalled response
    task automatic send(input logic [3:0] mt, input logic [paddr_w-1:0] addr, input logic [63:0] data,
                        input bit with_done, input logic [63:0] res, input bit no_yumi);
        logic [hdr_w-1:0]   hdr;
        logic [block_w-1:0] d;
        logic [63:0]        rv;
        logic [block_w-1:0] rdata;
        logic [msg_w-1:0]   exp;
        bit ok;
        bit done_set;
        bit started;
        int e;
        hdr = {16'($urandom_range(0, 65535)), 3'($urandom_range(0, 7)), addr, mt};
        d   = {$urandom(), $urandom(), data};
        io_cmd_i   = {d, hdr};
        io_cmd_v_i = 1'b1;
        done_i     = with_done;
        result_i   = res;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (io_cmd_ready_o === 1'b1) begin
                ok = 1;
                break;
            end
            step();
        end
        if (!ok) begin
            check("accept_timeout", 1'b0, 1'b1);
            io_cmd_v_i = 1'b0;
            done_i     = 1'b0;
            return;
        end
        step();
        e = edge_n;
        io_cmd_v_i = 1'b0;
        done_i     = 1'b0;

        rv    = model_read(addr, e);
        rdata = '0;
        if (mt == mt_uc_rd) rdata[63:0] = rv;
        exp = {rdata, hdr};
        exp_q.push_back(exp);
        last_exp = exp;

        done_set = 0;
        started  = 0;
        if (with_done && m_busy) begin
            m_busy   = 1'b0;
            m_done   = 1'b1;
            m_result = res;
            t_done   = e;
            done_set = 1;
        end
        if (mt == mt_uc_wr && addr[2:0] == 3'b0 && addr[11:6] == 6'b0) begin
            case (addr[5:3])
                3'd0: m_a   = data[paddr_w-1:0];
                3'd1: m_b   = data[paddr_w-1:0];
                3'd2: m_len = data[31:0];
                3'd3: if (data[0] && !m_busy) begin
                    m_busy  = 1'b1;
                    m_done  = 1'b0;
                    t_start = e;
                    started = 1;
                end
                3'd4: if (data[1] && !done_set) m_done = 1'b0;
                default: ;
            endcase
        end

        @(negedge clk);
        check("resp_v_latency", io_resp_v_o, 1'b1);
        check("ready_low", io_cmd_ready_o, 1'b0);
        check("start_o", start_o, started);
        check("busy_o", busy_o, m_busy);
        check("a_addr_o", a_addr_o, m_a);
        check("b_addr_o", b_addr_o, m_b);
        check("len_o", len_o, m_len);
        if (io_resp_v_o === 1'b1 && exp_q.size() > 0) begin
            check("resp", io_resp_o, exp_q.pop_front());
        end
        if (no_yumi) return;
        io_resp_yumi_i = 1'b1;
        step();
        io_resp_yumi_i = 1'b0;
    endtask

    task automatic wr(input logic [paddr_w-1:0] addr, input logic [63:0] data);
        send(mt_uc_wr, addr, data, 1'b0, '0, 1'b0);
    endtask

    task automatic rd(input logic [paddr_w-1:0] addr);
        send(mt_uc_rd, addr, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic pulse_done(input logic [63:0] res);
        done_i   = 1'b1;
        result_i = res;
        step();
        done_i = 1'b0;
        if (m_busy) begin
            m_busy   = 1'b0;
            m_done   = 1'b1;
            m_result = res;
            t_done   = edge_n;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s0;
        logic [3:0]         mt;
        logic [paddr_w-1:0] addr;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", io_cmd_ready_o, 1'b1);
        check("rst_resp_v", io_resp_v_o, 1'b0);
        check("rst_start", start_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_a_addr", a_addr_o, '0);
        check("rst_len", len_o, '0);
        step();

        // config registers and read-back
        wr(40'h00, 64'h8000_1000);
        wr(40'h08, 64'h8000_2000);
        wr(40'h10, 64'd16);
        rd(40'h00);
        rd(40'h08);
        rd(40'h10);
        check("a_addr_const", a_addr_o, 40'h8000_1000);

        // run, completion, status/result/cycles
        s0 = start_cnt;
        wr(40'h18, 64'h1);
        rd(40'h20);
        repeat (8) step();
        pulse_done(64'hDEAD_BEEF);
        rd(40'h20);
        rd(40'h28);
        rd(40'h30);
        check("start_pulses_1", start_cnt - s0, 1);

        // START while busy is ignored; W1C clears done
        s0 = start_cnt;
        wr(40'h18, 64'h1);
        wr(40'h18, 64'h1);
        rd(40'h20);
        check("start_pulses_busy", start_cnt - s0, 1);
        pulse_done(64'h1111_2222_3333_4444);
        wr(40'h20, 64'h2);
        rd(40'h20);

        // W1C in the same cycle as done: done stays set
        wr(40'h18, 64'h1);
        repeat (2) step();
        send(mt_uc_wr, 40'h20, 64'h2, 1'b1, 64'hABCD, 1'b0);
        rd(40'h20);
        wr(40'h20, 64'h2);
        rd(40'h20);

        // done coincident with START write: new run starts
        s0 = start_cnt;
        wr(40'h18, 64'h1);
        repeat (3) step();
        send(mt_uc_wr, 40'h18, 64'h1, 1'b1, 64'h1234, 1'b0);
        rd(40'h20);
        rd(40'h28);
        rd(40'h30);
        check("start_pulses_coinc", start_cnt - s0, 2);
        pulse_done(64'h5555);

        // unmapped / RO / unknown message types
        rd(40'h38);
        rd(40'h04);
        rd(40'h40);
        wr(40'h28, 64'hFFFF_FFFF);
        wr(40'h38, 64'h77);
        send(mt_amo, 40'h00, 64'h1234_5678, 1'b0, '0, 1'b0);
        send(mt_amo, 40'h18, 64'h1, 1'b0, '0, 1'b0);
        rd(40'hF0_0000_0000);
        rd(40'h28);
        rd(40'h00);

        // random mix
        for (int i = 0; i < 30; i++) begin
            int k;
            k = $urandom_range(0, 9);
            mt = (k < 5) ? mt_uc_rd : ((k < 9) ? mt_uc_wr : mt_amo);
            addr = '0;
            addr[5:3] = 3'($urandom_range(0, 7));
            addr[39:12] = 28'($urandom());
            if ($urandom_range(0, 5) == 0) addr[2:0] = 3'($urandom_range(1, 7));
            send(mt, addr, {$urandom(), $urandom()}, 1'b0, '0, 1'b0);
            if ($urandom_range(0, 3) == 0) pulse_done({$urandom(), $urandom()});
        end

        // stalled response, then reset mid-wait
        wr(40'h18, 64'h1);
        send(mt_uc_rd, 40'h00, '0, 1'b0, '0, 1'b1);
        io_cmd_i   = {64'h0, 64'h99, 16'h0, 3'd3, 40'h08, mt_uc_wr};
        io_cmd_v_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("stall_ready", io_cmd_ready_o, 1'b0);
            check("stall_resp_v", io_resp_v_o, 1'b1);
            check("stall_resp", io_resp_o, last_exp);
        end
        reset      = 1'b1;
        io_cmd_v_i = 1'b0;
        s0 = start_cnt;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_resp_v", io_resp_v_o, 1'b0);
        check("mid_rst_ready", io_cmd_ready_o, 1'b1);
        check("mid_rst_busy", busy_o, 1'b0);
        check("mid_rst_start", start_o, 1'b0);
        check("mid_rst_a", a_addr_o, '0);
        check("mid_rst_b", b_addr_o, '0);
        check("mid_rst_len", len_o, '0);
        check("mid_rst_no_start", start_cnt - s0, 0);
        exp_q.delete();
        model_reset();
        step();
        rd(40'h20);
        rd(40'h28);
        rd(40'h30);
        rd(40'h00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
